// File: rtl/uart_tx.sv
// UART transmit serializer: framed serial output driven by baud_tick,
// with a one-entry holding register so frames run back-to-back.
module uart_tx #(
  parameter int DATA_BITS = 8,  // 5..8 data bits per frame
  parameter int PARITY    = 0,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1   // 1 or 2 stop bits
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  // Parity over the low DATA_BITS bits only; odd parity is the inverted XOR.
  function automatic logic calc_parity(input logic [7:0] data);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < DATA_BITS) begin
        acc = acc ^ data[i];
      end else begin
        acc = acc;
      end
    end
    return (PARITY == 1) ? ~acc : acc;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] hold_r;
  logic       hold_full_r, hold_full_s;
  logic [7:0] shift_r, shift_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic       stop_cnt_r, stop_cnt_s;
  logic       par_r, par_s;
  logic       tx_r, tx_s;
  logic       frame_done_r, frame_done_s;
  logic       load_s;
  logic       accept_s;

  assign accept_s   = tx_valid & ~hold_full_r;
  assign tx_ready   = ~hold_full_r;
  assign tx         = tx_r;
  assign busy       = (state_r != S_IDLE);
  assign frame_done = frame_done_r;

  // Next-state and next-output logic; the FSM only moves on baud_tick cycles.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    stop_cnt_s   = stop_cnt_r;
    par_s        = par_r;
    tx_s         = tx_r;
    frame_done_s = 1'b0;
    load_s       = 1'b0;
    if (baud_tick) begin
      case (state_r)
        S_IDLE: begin
          if (hold_full_r) begin
            shift_s = hold_r;
            par_s   = calc_parity(hold_r);
            load_s  = 1'b1;
            tx_s    = 1'b0;
            state_s = S_START;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_START: begin
          tx_s      = shift_r[0];
          bit_cnt_s = 3'd0;
          state_s   = S_DATA;
        end
        S_DATA: begin
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_cnt_r < LAST_BIT) begin
            tx_s      = shift_r[1];
            bit_cnt_s = bit_cnt_r + 3'd1;
          end else if (PARITY != 0) begin
            tx_s    = par_r;
            state_s = S_PARITY;
          end else begin
            tx_s       = 1'b1;
            stop_cnt_s = 1'b0;
            state_s    = S_STOP;
          end
        end
        S_PARITY: begin
          tx_s       = 1'b1;
          stop_cnt_s = 1'b0;
          state_s    = S_STOP;
        end
        S_STOP: begin
          if (stop_cnt_r == STOP_LAST) begin
            frame_done_s = 1'b1;
            if (hold_full_r) begin
              // Chain straight into the next frame: no idle bit.
              shift_s = hold_r;
              par_s   = calc_parity(hold_r);
              load_s  = 1'b1;
              tx_s    = 1'b0;
              state_s = S_START;
            end else begin
              tx_s    = 1'b1;
              state_s = S_IDLE;
            end
          end else begin
            tx_s       = 1'b1;
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end
        default: begin
          tx_s    = 1'b1;
          state_s = S_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Holding register flag: cleared by a load, set by an accept (never both).
  always_comb begin
    if (load_s) begin
      hold_full_s = 1'b0;
    end else if (accept_s) begin
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  // State and datapath registers; reset drops any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      hold_r       <= 8'h00;
      hold_full_r  <= 1'b0;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      stop_cnt_r   <= 1'b0;
      par_r        <= 1'b0;
      tx_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      hold_r       <= accept_s ? tx_data : hold_r;
      hold_full_r  <= hold_full_s;
      shift_r      <= shift_s;
      bit_cnt_r    <= bit_cnt_s;
      stop_cnt_r   <= stop_cnt_s;
      par_r        <= par_s;
      tx_r         <= tx_s;
      frame_done_r <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three configurations (8N1, 7E1, 8O2)
// compared tick by tick against a frame-level reference model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] valid_v = 3'b000;
  logic [2:0] ready_v, tx_v, busy_v, fd_v;

  int tests_run = 0;
  int tests_failed = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS((g == 1) ? 7 : 8),
      .PARITY   ((g == 0) ? 0 : ((g == 1) ? 2 : 1)),
      .STOP_BITS((g == 2) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .tx_data   (tx_data),
      .tx_valid  (valid_v[g]),
      .tx_ready  (ready_v[g]),
      .tx        (tx_v[g]),
      .busy      (busy_v[g]),
      .frame_done(fd_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cfg_db(input int g);  return (g == 1) ? 7 : 8; endfunction
  function automatic int cfg_par(input int g); return (g == 0) ? 0 : ((g == 1) ? 2 : 1); endfunction
  function automatic int cfg_sb(input int g);  return (g == 2) ? 2 : 1; endfunction
  function automatic int flen(input int g);
    return 1 + cfg_db(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_sb(g);
  endfunction

  // Reference frame: start, data LSB first, parity from a ones count, stop bits.
  function automatic void add_frame(input int g, input bit [7:0] b);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_db(g); i++) begin
      exp_q.push_back(b[i]);
      ones += b[i];
    end
    if (cfg_par(g) == 2) exp_q.push_back(bit'(ones % 2));
    if (cfg_par(g) == 1) exp_q.push_back(bit'((ones % 2) == 0));
    for (int i = 0; i < cfg_sb(g); i++) exp_q.push_back(1'b1);
  endfunction

  // One tick pulse, then sample; gap idle cycles follow.
  task automatic do_tick(input int gap);
    @(negedge clk) baud_tick = 1'b1;
    @(negedge clk) baud_tick = 1'b0;
  endtask

  // Send n bytes on DUT g back-to-back and check every bit period.
  task automatic run_burst(input int g, input int n, input int gap, input bit sync_first,
                           input bit [7:0] b0, input bit [7:0] b1);
    bit [7:0] bq[$];
    int nl;
    nl = flen(g);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bit [7:0] b;
      b = (i == 0) ? b0 : ((i == 1) ? b1 : 8'($urandom_range(255, 0)));
      bq.push_back(b);
      add_frame(g, b);
    end
    @(negedge clk);
    tx_data = bq[0];
    valid_v[g] = 1'b1;
    if (sync_first) baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    valid_v[g] = 1'b0;
    check("accept_ready_low", ready_v[g], 0);
    check("accept_tx_idle", tx_v[g], 1);
    check("accept_not_busy", busy_v[g], 0);
    fork
      begin : feeder
        for (int i = 1; i < n; i++) begin
          int w = 0;
          tx_data = bq[i];
          valid_v[g] = 1'b1;
          while (!ready_v[g] && w < 5000) begin
            @(negedge clk);
            w++;
          end
          check("feed_timeout", (w < 5000) ? 1 : 0, 1);
          @(negedge clk);
          valid_v[g] = 1'b0;
          check("hold_ready_low", ready_v[g], 0);
        end
      end
      begin : ticker
        for (int t = 1; t <= n * nl + 2; t++) begin
          logic etx, ebusy, efd;
          do_tick(gap);
          etx   = (t <= n * nl) ? exp_q[t-1] : 1'b1;
          ebusy = (t <= n * nl) ? 1'b1 : 1'b0;
          efd   = (t > 1 && ((t - 1) % nl) == 0) ? 1'b1 : 1'b0;
          check("tx_bit", tx_v[g], etx);
          check("busy", busy_v[g], ebusy);
          check("frame_done", fd_v[g], efd);
          if (gap > 0) begin
            repeat (gap) @(negedge clk);
            check("tx_hold_between_ticks", tx_v[g], etx);
            check("frame_done_one_cycle", fd_v[g], 0);
          end
        end
      end
    join
  endtask

  initial begin
    #12;
    for (int g = 0; g < 3; g++) begin
      check("reset_tx", tx_v[g], 1);
      check("reset_busy", busy_v[g], 0);
      check("reset_ready", ready_v[g], 1);
      check("reset_fd", fd_v[g], 0);
    end
    @(negedge clk) rst_n = 1'b1;

    run_burst(0, 1, 0, 1'b0, 8'hA5, 8'h00);
    run_burst(1, 1, 0, 1'b0, 8'hC1, 8'h00);
    run_burst(2, 1, 1, 1'b0, 8'h03, 8'h00);
    run_burst(0, 2, 0, 1'b0, 8'h55, 8'hAA);

    // Reset mid-frame with the hold register full.
    @(negedge clk);
    tx_data = 8'hF0;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    do_tick(0);
    tx_data = 8'h0F;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    do_tick(0);
    do_tick(0);
    do_tick(0);
    check("pre_reset_tx", tx_v[0], 0);
    check("pre_reset_ready", ready_v[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx_v[0], 1);
    check("async_reset_busy", busy_v[0], 0);
    check("async_reset_ready", ready_v[0], 1);
    @(negedge clk) rst_n = 1'b1;
    run_burst(0, 1, 0, 1'b0, 8'h0F, 8'h00);

    // Accept coinciding with a tick, dense and sparse ticks.
    run_burst(0, 1, 0, 1'b1, 8'h81, 8'h00);
    run_burst(0, 1, 35, 1'b1, 8'h81, 8'h00);

    for (int k = 0; k < 24; k++) begin
      run_burst(int'($urandom_range(2, 0)), int'($urandom_range(3, 1)),
                int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
